// File: rtl/sprite_blitter.sv
// Render-command consumer: pops FIFO commands, streams sprite pixels from image
// memory one per clock, and writes visible, non-key pixels to the frame buffer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for cmd_valid; pops one command per cycle
// S_RUN   | issuing sprite read addresses, one per unstalled cycle
// S_DRAIN | last address issued; waiting for pipeline and write to retire
module sprite_blitter #(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter logic [23:0] TRANSPARENT = 24'hFF00FF
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [47:0] cmd_data,
    output logic        cmd_pop,
    output logic [19:0] pix_addr,
    input  logic [23:0] pix_din,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [23:0] fb_data,
    input  logic        fb_wready,
    output logic        busy
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic [CW-1:0] r_a_col;
    logic [RW-1:0] r_a_row;
    logic          r_a_vld;
    logic [CW-1:0] r_b_col;
    logic [RW-1:0] r_b_row;
    logic          r_b_vld;
    logic [23:0]   r_b_hold;
    logic          r_stall_q;

    logic          w_stall;
    logic          w_is_blit;
    logic          w_a_last;
    logic [23:0]   w_b_data;
    logic [10:0]   w_sx;
    logic [10:0]   w_sy;
    logic          w_visible;
    logic [18:0]   w_fb_addr;

    assign w_stall   = fb_we && !fb_wready;
    assign w_is_blit = (cmd_data[47:40] == 8'h01);
    assign w_a_last  = r_a_vld && (r_a_col == CW'(SPRITE_W - 1))
                               && (r_a_row == RW'(SPRITE_H - 1));

    // Memory keeps re-reading the frozen address during a stall, which returns
    // the word after the one stage B owns; hold stage B's word until release.
    assign w_b_data  = r_stall_q ? r_b_hold : pix_din;

    assign w_sx      = {1'b0, r_x} + 11'(r_b_col);
    assign w_sy      = {1'b0, r_y} + 11'(r_b_row);
    assign w_visible = (w_b_data != TRANSPARENT)
                    && (w_sx < 11'(SCREEN_W))
                    && (w_sy < 11'(SCREEN_H));
    assign w_fb_addr = 19'(32'(w_sy) * 32'(SCREEN_W) + 32'(w_sx));

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_pop     = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && !reset) begin
                    cmd_pop = 1'b1;
                    if (w_is_blit) begin
                        busy        = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (!w_stall && w_a_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!r_a_vld && !r_b_vld && !w_stall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_x       <= '0;
            r_y       <= '0;
            pix_addr  <= '0;
            r_a_col   <= '0;
            r_a_row   <= '0;
            r_a_vld   <= 1'b0;
            r_b_col   <= '0;
            r_b_row   <= '0;
            r_b_vld   <= 1'b0;
            r_b_hold  <= '0;
            r_stall_q <= 1'b0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_data   <= '0;
        end else begin
            if (cmd_pop && w_is_blit) begin
                r_x      <= cmd_data[39:30];
                r_y      <= cmd_data[29:20];
                pix_addr <= cmd_data[19:0];
                r_a_col  <= '0;
                r_a_row  <= '0;
                r_a_vld  <= 1'b1;
            end else if (!w_stall && r_a_vld) begin
                if (w_a_last) begin
                    r_a_vld <= 1'b0;
                end else begin
                    // Row-major scan of a SPRITE_W-wide sprite is a linear walk.
                    pix_addr <= pix_addr + 20'd1;
                    r_a_col  <= r_a_col + 1'b1;
                    if (r_a_col == CW'(SPRITE_W - 1)) begin
                        r_a_row <= r_a_row + 1'b1;
                    end
                end
            end

            if (!w_stall) begin
                r_b_vld <= r_a_vld;
                r_b_col <= r_a_col;
                r_b_row <= r_a_row;
                fb_we   <= r_b_vld && w_visible;
                if (r_b_vld && w_visible) begin
                    fb_addr <= w_fb_addr;
                    fb_data <= w_b_data;
                end
            end

            r_stall_q <= w_stall;
            if (w_stall) begin
                r_b_hold <= w_b_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter (4x4 sprites): directed table, stall, discard,
// reset and randomized commands against a per-pixel reference model.
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [47:0] cmd_data;
    logic        cmd_pop;
    logic [19:0] pix_addr;
    logic [23:0] pix_din;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [23:0] fb_data;
    logic        fb_wready;
    logic        busy;

    sprite_blitter #(
        .SPRITE_W(4),
        .SPRITE_H(4)
    ) dut (
        .clk50    (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_data (cmd_data),
        .cmd_pop  (cmd_pop),
        .pix_addr (pix_addr),
        .pix_din  (pix_din),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_wready(fb_wready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Image memory: word = {4'h0, addr}, optionally one address holds the key.
    bit          key_en = 1'b0;
    logic [19:0] key_addr = '0;

    function automatic logic [23:0] mem_word(input logic [19:0] a);
        return (key_en && a == key_addr) ? 24'hFF00FF : {4'h0, a};
    endfunction

    always @(posedge clk) pix_din <= mem_word(pix_addr);

    // Frame-buffer ready driver: 0 = always ready, 1 = window stall, 2 = random.
    int rdy_mode = 0;
    int stall_from = 0;
    int stall_len = 0;
    initial begin
        fb_wready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1)
                fb_wready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            else if (rdy_mode == 2)
                fb_wready = ($urandom_range(0, 3) != 0);
            else
                fb_wready = 1'b1;
        end
    end

    // Write monitor: accepted writes in order, plus we/stall cycle counts.
    logic [18:0] act_addr[$];
    logic [23:0] act_data[$];
    int          act_cyc[$];
    int          we_cnt = 0;
    int          stall_cnt = 0;
    always @(negedge clk) begin
        if (fb_we && fb_wready) begin
            act_addr.push_back(fb_addr);
            act_data.push_back(fb_data);
            act_cyc.push_back(cyc);
        end
        if (fb_we) we_cnt <= we_cnt + 1;
        if (fb_we && !fb_wready) stall_cnt <= stall_cnt + 1;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: every sprite pixel, keyed/off-screen ones dropped.
    logic [18:0] exp_addr[$];
    logic [23:0] exp_data[$];

    task automatic build_exp(input logic [9:0] x, input logic [9:0] y, input logic [19:0] base);
        logic [19:0] a;
        logic [23:0] d;
        exp_addr.delete();
        exp_data.delete();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a = base + 20'(r * 4 + c);
                d = mem_word(a);
                if (d != 24'hFF00FF && int'(x) + c < 640 && int'(y) + r < 480) begin
                    exp_addr.push_back(19'((int'(y) + r) * 640 + int'(x) + c));
                    exp_data.push_back(d);
                end
            end
        end
    endtask

    task automatic compare_model(input int s, input string name);
        int n;
        n = act_addr.size() - s;
        chk({name, " write count"}, n, exp_addr.size());
        for (int i = 0; i < n && i < exp_addr.size(); i++) begin
            chk({name, " fb_addr"}, act_addr[s + i], exp_addr[i]);
            chk({name, " fb_data"}, act_data[s + i], exp_data[i]);
        end
    endtask

    task automatic issue(input logic [47:0] cmd, output int p, output logic b_at_pop);
        bit got;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_data  = cmd;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_pop) begin
                got = 1'b1;
                break;
            end
        end
        chk("pop seen", got, 1);
        p = cyc;
        b_at_pop = busy;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle reached", ok, 1);
        d = cyc;
        #1;
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [19:0] base;
        bit          key;
        logic [19:0] key_a;
        int          n;
        logic [18:0] a_first;
        logic [18:0] a_last;
        logic [23:0] d_first;
        logic [23:0] d_last;
        int          first_cyc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int p, p2, d, s, we0, st0, pops, late, early;
        logic b;
        logic [19:0] pa, rb;
        logic [9:0] rx, ry;
        logic [7:0] op;
        bit got;

        vecs[0] = '{10'd0,   10'd0,   20'h10,    1'b0, 20'h0,  16, 19'd0,      19'd1923,   24'h10,    24'h1F,    3};
        vecs[1] = '{10'd0,   10'd0,   20'h10,    1'b1, 20'h15, 15, 19'd0,      19'd1923,   24'h10,    24'h1F,    3};
        vecs[2] = '{10'd638, 10'd478, 20'h10,    1'b0, 20'h0,  4,  19'd306558, 19'd307199, 24'h10,    24'h15,    3};
        vecs[3] = '{10'd0,   10'd0,   20'hFFFFE, 1'b0, 20'h0,  16, 19'd0,      19'd1923,   24'hFFFFE, 24'h0000D, 3};
        vecs[4] = '{10'd639, 10'd0,   20'h0,     1'b0, 20'h0,  4,  19'd639,    19'd2559,   24'h0,     24'hC,     3};
        vecs[5] = '{10'd0,   10'd479, 20'h100,   1'b0, 20'h0,  4,  19'd306560, 19'd306563, 24'h100,   24'h103,   3};
        vecs[6] = '{10'd1023,10'd1023,20'h5,     1'b0, 20'h0,  0,  19'd0,      19'd0,      24'h0,     24'h0,    -1};

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset cmd_pop", cmd_pop, 0);
        chk("reset fb_we", fb_we, 0);
        chk("reset busy", busy, 0);
        chk("reset pix_addr", pix_addr, 0);
        chk("reset fb_addr", fb_addr, 0);
        chk("reset fb_data", fb_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            key_en = vecs[i].key;
            key_addr = vecs[i].key_a;
            build_exp(vecs[i].x, vecs[i].y, vecs[i].base);
            s = act_addr.size();
            issue({8'h01, vecs[i].x, vecs[i].y, vecs[i].base}, p, b);
            chk("busy at pop", b, 1);
            wait_idle(d);
            chk("completion latency", d - p, 19);
            chk("table write count", act_addr.size() - s, vecs[i].n);
            if (act_addr.size() > s && vecs[i].n > 0) begin
                chk("table first addr", act_addr[s], vecs[i].a_first);
                chk("table last addr", act_addr[act_addr.size() - 1], vecs[i].a_last);
                chk("table first data", act_data[s], vecs[i].d_first);
                chk("table last data", act_data[act_data.size() - 1], vecs[i].d_last);
                chk("first write cycle", act_cyc[s] - p, vecs[i].first_cyc);
            end
            compare_model(s, "table");
        end
        key_en = 1'b0;

        // Stall on the 3rd write for 5 cycles
        build_exp(10'd0, 10'd0, 20'h10);
        s = act_addr.size();
        we0 = we_cnt;
        st0 = stall_cnt;
        issue({8'h01, 10'd0, 10'd0, 20'h10}, p, b);
        stall_from = p + 5;
        stall_len = 5;
        rdy_mode = 1;
        wait_idle(d);
        rdy_mode = 0;
        chk("stall completion", d - p, 24);
        chk("stall we cycles", we_cnt - we0, 21);
        chk("stall cycles", stall_cnt - st0, 5);
        compare_model(s, "stall");

        // Discarded opcode followed by BLIT
        build_exp(10'd0, 10'd0, 20'h20);
        s = act_addr.size();
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_data = {8'h07, 10'd5, 10'd5, 20'h40};
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_pop) begin
                got = 1'b1;
                break;
            end
        end
        chk("discard pop seen", got, 1);
        chk("discard busy", busy, 0);
        pa = pix_addr;
        @(posedge clk);
        #1;
        cmd_data = {8'h01, 10'd0, 10'd0, 20'h20};
        @(negedge clk);
        chk("second pop next cycle", cmd_pop, 1);
        chk("no reads on discard", pix_addr, pa);
        p2 = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle(d);
        chk("post-discard latency", d - p2, 19);
        if (act_addr.size() > s) chk("post-discard first write", act_cyc[s] - p2, 3);
        compare_model(s, "discard");

        // Reset in the middle of a sprite
        issue({8'h01, 10'd0, 10'd0, 20'h10}, p, b);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after reset fb_we", fb_we, 0);
        chk("after reset busy", busy, 0);
        chk("after reset cmd_pop", cmd_pop, 0);
        pops = 0;
        repeat (30) begin
            @(negedge clk);
            if (cmd_pop) pops++;
        end
        #1;
        late = 0;
        early = 0;
        foreach (act_cyc[i]) begin
            if (act_cyc[i] > p + 8) late++;
            else if (act_cyc[i] >= p + 3) early++;
        end
        chk("no pop without valid", pops, 0);
        chk("writes after reset", late, 0);
        chk("writes before reset", early, 6);

        // Randomized commands with random backpressure
        rdy_mode = 2;
        for (int k = 0; k < 12; k++) begin
            op = ($urandom_range(0, 4) == 0) ? 8'h5A : 8'h01;
            rx = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(628, 645)) : 10'($urandom_range(0, 1023));
            ry = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(468, 485)) : 10'($urandom_range(0, 1023));
            rb = 20'($urandom);
            key_en = ($urandom_range(0, 1) != 0);
            key_addr = rb + 20'($urandom_range(0, 15));
            s = act_addr.size();
            if (op == 8'h01) begin
                build_exp(rx, ry, rb);
                st0 = stall_cnt;
                issue({op, rx, ry, rb}, p, b);
                chk("rand busy at pop", b, 1);
                wait_idle(d);
                chk("rand latency", d - p, 19 + (stall_cnt - st0));
                compare_model(s, "rand");
            end else begin
                issue({op, rx, ry, rb}, p, b);
                chk("rand discard busy", b, 0);
                pa = pix_addr;
                repeat (4) @(negedge clk);
                #1;
                chk("rand discard writes", act_addr.size() - s, 0);
                chk("rand discard pix_addr", pix_addr, pa);
            end
        end
        rdy_mode = 0;
        key_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
